// File: rtl/mode_stepper_pkg.sv
// Shared encodings for the mode stepper: FSM states and button direction.
package mode_stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // Both buttons together count as released.
    function automatic dir_t decode_dir(input logic up, input logic down);
        if (up && !down) begin
            return DIR_UP;
        end
        if (down && !up) begin
            return DIR_DOWN;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running rate tick: one-cycle pulse every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4545454
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Divider counter, cleared on reset and after the terminal count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_o = (count == LAST);

endmodule

// File: rtl/mode_stepper.sv
// Bounded up/down value stepper with hold-to-repeat, skip code and load path.
module mode_stepper
    import mode_stepper_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned MIN_VAL      = 1,
    parameter int unsigned MAX_VAL      = 8,
    parameter int unsigned SKIP_EN      = 1,
    parameter int unsigned SKIP_VAL     = 7,
    parameter int unsigned RESET_VAL    = 1,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned TICK_DIV     = 4545454,
    parameter int unsigned REPEAT_TICKS = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] val_o,
    output logic             changed_o,
    output logic             load_err_o
);

    localparam int unsigned CNTW = $clog2(REPEAT_TICKS + 1);
    localparam logic [CNTW-1:0] REP_LAST = CNTW'(REPEAT_TICKS - 1);
    localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] SKIP_W = (WIDTH+1)'(SKIP_VAL);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    if (MIN_VAL >= MAX_VAL || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_range
        $error("mode_stepper: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (SKIP_EN != 0 && (SKIP_VAL <= MIN_VAL || SKIP_VAL >= MAX_VAL)) begin : g_bad_skip
        $error("mode_stepper: SKIP_VAL must lie strictly between MIN_VAL and MAX_VAL");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL ||
        (SKIP_EN != 0 && RESET_VAL == SKIP_VAL)) begin : g_bad_reset
        $error("mode_stepper: RESET_VAL must be a legal value");
    end
    if (TICK_DIV < 2 || REPEAT_TICKS < 1) begin : g_bad_timing
        $error("mode_stepper: need TICK_DIV >= 2 and REPEAT_TICKS >= 1");
    end

    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] w;
        w = {1'b0, v};
        return (w >= MIN_W) && (w <= MAX_W) && !(SKIP_EN != 0 && w == SKIP_W);
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        if ({1'b0, v} == MAX_W) begin
            r = (WRAP != 0) ? MIN_W : MAX_W;
        end else begin
            r = {1'b0, v} + ONE_W;
            if (SKIP_EN != 0 && r == SKIP_W) begin
                r = r + ONE_W;
            end
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        if ({1'b0, v} == MIN_W) begin
            r = (WRAP != 0) ? MAX_W : MIN_W;
        end else begin
            r = {1'b0, v} - ONE_W;
            if (SKIP_EN != 0 && r == SKIP_W) begin
                r = r - ONE_W;
            end
        end
        return r[WIDTH-1:0];
    endfunction

    logic             tick;
    logic [1:0]       up_sync;
    logic [1:0]       down_sync;
    dir_t             dir;
    state_t           state, state_n;
    dir_t             held, held_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic             do_step;
    logic [WIDTH-1:0] val, val_n;
    logic             changed;
    logic             load_err, load_err_n;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // Two-stage synchronisers for the raw button levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_sync   <= '0;
            down_sync <= '0;
        end else begin
            up_sync   <= {up_sync[0], up_i};
            down_sync <= {down_sync[0], down_i};
        end
    end

    assign dir = decode_dir(up_sync[1], down_sync[1]);

    // Press/hold/repeat decisions, taken only on rate ticks.
    always_comb begin
        state_n = state;
        held_n  = held;
        cnt_n   = cnt;
        do_step = 1'b0;
        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (dir != DIR_NONE) begin
                        do_step = 1'b1;
                        held_n  = dir;
                        cnt_n   = '0;
                        state_n = (REPEAT_TICKS <= 1) ? ST_REPEAT : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dir == DIR_NONE) begin
                        state_n = ST_IDLE;
                    end else if (dir != held) begin
                        do_step = 1'b1;
                        held_n  = dir;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNTW'(1);
                        // The tick that completes the hold period is also the first repeat step.
                        if (cnt_n >= REP_LAST) begin
                            do_step = 1'b1;
                            state_n = ST_REPEAT;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (dir == DIR_NONE) begin
                        state_n = ST_IDLE;
                    end else if (dir != held) begin
                        do_step = 1'b1;
                        held_n  = dir;
                        cnt_n   = '0;
                        state_n = ST_HOLD;
                    end else begin
                        do_step = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Next value: a load wins over a same-cycle step.
    always_comb begin
        val_n      = val;
        load_err_n = 1'b0;
        if (load_i) begin
            if (is_legal(load_val_i)) begin
                val_n = load_val_i;
            end else begin
                load_err_n = 1'b1;
            end
        end else if (do_step) begin
            val_n = (held_n == DIR_UP) ? step_up(val) : step_down(val);
        end
    end

    // State, value and pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            held     <= DIR_NONE;
            cnt      <= '0;
            val      <= RESET_V;
            changed  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            held     <= held_n;
            cnt      <= cnt_n;
            val      <= val_n;
            changed  <= (val_n != val);
            load_err <= load_err_n;
        end
    end

    assign val_o      = val;
    assign changed_o  = changed;
    assign load_err_o = load_err;

endmodule

// File: tb/tb_mode_stepper.sv
// Directed self-checking bench for mode_stepper (TICK_DIV=4, REPEAT_TICKS=3).
module tb_mode_stepper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] val;
    logic       chg, err;

    logic       up2 = 1'b0, down2 = 1'b0, load2 = 1'b0;
    logic [3:0] load_val2 = '0;
    logic [3:0] val2;
    logic       chg2, err2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    mode_stepper #(.TICK_DIV(4), .REPEAT_TICKS(3)) dut (
        .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(down),
        .load_i(load), .load_val_i(load_val),
        .val_o(val), .changed_o(chg), .load_err_o(err)
    );

    mode_stepper #(.TICK_DIV(4), .REPEAT_TICKS(3), .WRAP(0)) dut_sat (
        .clk_i(clk), .rst_i(rst), .up_i(up2), .down_i(down2),
        .load_i(load2), .load_val_i(load_val2),
        .val_o(val2), .changed_o(chg2), .load_err_o(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] lv;
        int         exp_val;
        int         exp_chg;
        int         exp_err;
    } ld_vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_changes(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (chg) c++;
        end
    endtask

    task automatic wait_change(input string name, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit && at < 0; k++) begin
            @(negedge clk);
            if (chg) at = cyc;
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: changed_o got none expected pulse within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_vec_t tab[10];
        int c;
        int t[6];
        int exp3[5];
        int got;
        logic seen;

        tab[0] = '{4'd7,  1, 0, 1};
        tab[1] = '{4'd0,  1, 0, 1};
        tab[2] = '{4'd9,  1, 0, 1};
        tab[3] = '{4'd15, 1, 0, 1};
        tab[4] = '{4'd4,  4, 1, 0};
        tab[5] = '{4'd4,  4, 0, 0};
        tab[6] = '{4'd8,  8, 1, 0};
        tab[7] = '{4'd7,  8, 0, 1};
        tab[8] = '{4'd1,  1, 1, 0};
        tab[9] = '{4'd6,  6, 1, 0};

        // Reset state and idle stability
        repeat (3) @(negedge clk);
        check("reset_val", int'(val), 1);
        check("reset_chg", int'(chg), 0);
        check("reset_err", int'(err), 0);
        check("reset_val_sat", int'(val2), 1);
        rst = 1'b0;
        count_changes(40, c);
        check("idle_changes", c, 0);
        check("idle_val", int'(val), 1);

        // Load table: legal/illegal codes, pulse width
        for (int i = 0; i < 10; i++) begin
            do_load(tab[i].lv);
            check($sformatf("load%0d_val", i), int'(val), tab[i].exp_val);
            check($sformatf("load%0d_chg", i), int'(chg), tab[i].exp_chg);
            check($sformatf("load%0d_err", i), int'(err), tab[i].exp_err);
            @(negedge clk);
            check($sformatf("load%0d_pulse", i), int'(chg | err), 0);
        end

        // Tap up from 6 skips 7, then tap at 8 wraps to 1
        up = 1'b1;
        wait_change("tap1", 20, got);
        up = 1'b0;
        check("tap1_val", int'(val), 8);
        count_changes(12, c);
        check("tap1_single", c, 0);
        up = 1'b1;
        wait_change("tap2", 20, got);
        up = 1'b0;
        check("tap2_wrap", int'(val), 1);
        count_changes(12, c);
        check("tap2_single", c, 0);

        // Hold down from 3: first step, hold period, then repeat with wrap and skip
        do_load(4'd3);
        exp3 = '{2, 1, 8, 6, 5};
        down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_change($sformatf("hold_dn%0d", i), 20, t[i]);
            check($sformatf("hold_dn%0d_val", i), int'(val), exp3[i]);
        end
        down = 1'b0;
        check("hold_gap0", t[1] - t[0], 8);
        check("hold_gap1", t[2] - t[1], 4);
        check("hold_gap3", t[4] - t[3], 4);
        count_changes(12, c);
        check("hold_release", c, 0);

        // Load beats a step decided in the same tick cycle
        do_load(4'd1);
        up = 1'b1;
        wait_change("al0", 20, t[0]);
        check("al0_val", int'(val), 2);
        wait_change("al1", 20, t[1]);
        check("al1_val", int'(val), 3);
        repeat (3) @(negedge clk);
        load = 1'b1;
        load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        up = 1'b0;
        check("al_load_val", int'(val), 5);
        check("al_load_chg", int'(chg), 1);
        count_changes(12, c);
        check("al_after", c, 0);
        check("al_after_val", int'(val), 5);

        // Saturating instance: no movement and no pulse at the bounds
        @(negedge clk);
        load2 = 1'b1;
        load_val2 = 4'd8;
        @(negedge clk);
        load2 = 1'b0;
        check("sat_load8", int'(val2), 8);
        up2 = 1'b1;
        c = 0;
        repeat (40) begin
            @(negedge clk);
            if (chg2) c++;
        end
        up2 = 1'b0;
        check("sat_top_chg", c, 0);
        check("sat_top_val", int'(val2), 8);
        repeat (6) @(negedge clk);
        load2 = 1'b1;
        load_val2 = 4'd1;
        @(negedge clk);
        load2 = 1'b0;
        check("sat_load1", int'(val2), 1);
        down2 = 1'b1;
        c = 0;
        repeat (40) begin
            @(negedge clk);
            if (chg2) c++;
        end
        down2 = 1'b0;
        check("sat_bot_chg", c, 0);
        check("sat_bot_val", int'(val2), 1);
        repeat (6) @(negedge clk);
        up2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (chg2) seen = 1'b1;
        end
        up2 = 1'b0;
        check("sat_step_seen", int'(seen), 1);
        check("sat_step_val", int'(val2), 2);

        // Both buttons: no step; then up alone starts a fresh press
        repeat (6) @(negedge clk);
        up = 1'b1;
        down = 1'b1;
        count_changes(30, c);
        check("both_chg", c, 0);
        check("both_val", int'(val), 5);
        down = 1'b0;
        exp3 = '{6, 8, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            wait_change($sformatf("solo%0d", i), 20, t[i]);
            check($sformatf("solo%0d_val", i), int'(val), exp3[i]);
        end
        check("solo_gap0", t[1] - t[0], 8);
        check("solo_gap2", t[3] - t[2], 4);

        // Reset during repeat, button still held is a new press
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_val", int'(val), 1);
        check("mid_rst_chg", int'(chg), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_change("post_rst0", 20, t[0]);
        check("post_rst0_val", int'(val), 2);
        wait_change("post_rst1", 20, t[1]);
        check("post_rst1_val", int'(val), 3);
        check("post_rst_gap", t[1] - t[0], 8);
        up = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
